// File: rtl/wb_pkg.sv
// Shared definitions for the registered writeback stage: opcodes, load funct3 codes,
// address-region nibbles, writeback source and FSM state enums.
package wb_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_CSR    = 7'h73;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [3:0] REGION_BIOS = 4'h4;
    localparam logic [3:0] REGION_MMIO = 4'h8;

    typedef enum logic [2:0] {
        SRC_ALU  = 3'd0,
        SRC_PC4  = 3'd1,
        SRC_DMEM = 3'd2,
        SRC_BIOS = 3'd3,
        SRC_MMIO = 3'd4
    } wb_src_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } wb_state_e;

    // Opcodes whose instruction format carries a destination register (R, I, load, U, JAL, JALR).
    function automatic logic writes_rd(input logic [6:0] opcode);
        logic w;
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_CSR, OPC_LOAD,
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: w = 1'b1;
            default:                               w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/wb_stage_unit_load_align.sv
// Sub-word load extraction: selects byte/half/word from a read word by funct3 and
// address offset, with sign or zero extension.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      offset_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection; halfword accesses ignore offset bit 0.
    always_comb begin
        byte_s = data_i[7:0];
        case (offset_i)
            2'd0:    byte_s = data_i[7:0];
            2'd1:    byte_s = data_i[15:8];
            2'd2:    byte_s = data_i[23:16];
            2'd3:    byte_s = data_i[31:24];
            default: byte_s = data_i[7:0];
        endcase
        if (offset_i[1]) begin
            half_s = data_i[31:16];
        end else begin
            half_s = data_i[15:0];
        end
    end

    // Extension by access type.
    always_comb begin
        data_o = data_i;
        case (funct3_i)
            F3_LB:   data_o = {{(XLEN-8){byte_s[7]}}, byte_s};
            F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_s};
            F3_LH:   data_o = {{(XLEN-16){half_s[15]}}, half_s};
            F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_s};
            F3_LW:   data_o = data_i;
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/wb_stage_unit.sv
// Registered writeback stage: X->W register, writeback source select, load extraction
// and RUN/WAIT handshake for slow MMIO channels. Optional timeout: WB_MMIO_TIMEOUT_EN.
module wb_stage_unit
    import wb_pkg::*;
#(
    parameter int                XLEN      = 32,
    parameter int                N_MMIO    = 8,
    parameter logic [XLEN-1:0]   MMIO_BASE = 32'h8000_0000,
    parameter logic [N_MMIO-1:0] SLOW_MASK = 8'b1100_0000,
    parameter int                TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   x_valid,
    input  logic [XLEN-1:0]        x_inst,
    input  logic [XLEN-1:0]        x_addr,
    input  logic [XLEN-1:0]        x_pc,
    input  logic [XLEN-1:0]        dmem_rdata,
    input  logic [XLEN-1:0]        bios_rdata,
    input  logic [N_MMIO*XLEN-1:0] mmio_rdata,
    input  logic [N_MMIO-1:0]      mmio_ack,
    output logic [N_MMIO-1:0]      mmio_req,
    output logic                   stall,
    output logic                   wb_we,
    output logic [4:0]             wb_rd,
    output logic [XLEN-1:0]        wb_data,
    output logic                   bus_err
);

    localparam int IDX_W = (N_MMIO > 1) ? $clog2(N_MMIO) : 1;
    // Address bits between the channel index and the region nibble must be zero.
    localparam logic [XLEN-1:0] MID_MASK = XLEN'((64'h1 << 28) - (64'h1 << (2 + IDX_W)));

    wb_state_e         state_q, state_d;
    logic              w_valid_q, w_valid_d;
    logic [XLEN-1:0]   w_inst_q, w_inst_d;
    logic [XLEN-1:0]   w_addr_q, w_addr_d;
    logic [XLEN-1:0]   w_pc_q, w_pc_d;

    logic [6:0]        opcode_s;
    logic [2:0]        funct3_s;
    logic [4:0]        rd_s;
    logic              is_load_s;
    logic              is_jump_s;
    wb_src_e           src_s;
    logic [IDX_W-1:0]  mmio_idx_s;
    logic              mmio_region_s;
    logic              mmio_hit_s;
    logic              mmio_ok_s;
    logic              mmio_slow_s;
    logic [N_MMIO-1:0] mmio_onehot_s;
    logic [XLEN-1:0]   mmio_word_s;
    logic [XLEN-1:0]   raw_s;
    logic [XLEN-1:0]   aligned_s;
    logic [XLEN-1:0]   result_s;
    logic              slow_load_s;
    logic              ack_hit_s;
    logic              tmo_hit_s;
    logic              stall_s;
    logic              bus_err_s;
    logic [N_MMIO-1:0] req_s;
    logic              unused_inst_s;

    assign opcode_s      = w_inst_q[6:0];
    assign rd_s          = w_inst_q[11:7];
    assign funct3_s      = w_inst_q[14:12];
    assign unused_inst_s = ^w_inst_q[XLEN-1:15];
    assign is_load_s     = (opcode_s == OPC_LOAD);
    assign is_jump_s     = (opcode_s == OPC_JAL) || (opcode_s == OPC_JALR);
    assign mmio_idx_s    = w_addr_q[2 +: IDX_W];
    assign mmio_region_s = (w_addr_q[31:28] == MMIO_BASE[31:28]);
    assign mmio_ok_s     = mmio_hit_s && ((w_addr_q & MID_MASK) == '0);

    // State and W pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            w_valid_q <= 1'b0;
            w_inst_q  <= '0;
            w_addr_q  <= '0;
            w_pc_q    <= '0;
        end else begin
            state_q   <= state_d;
            w_valid_q <= w_valid_d;
            w_inst_q  <= w_inst_d;
            w_addr_q  <= w_addr_d;
            w_pc_q    <= w_pc_d;
        end
    end

    // W register captures X while the pipeline advances, holds while stalled.
    always_comb begin
        if (!stall_s) begin
            w_valid_d = x_valid;
            w_inst_d  = x_inst;
            w_addr_d  = x_addr;
            w_pc_d    = x_pc;
        end else begin
            w_valid_d = w_valid_q;
            w_inst_d  = w_inst_q;
            w_addr_d  = w_addr_q;
            w_pc_d    = w_pc_q;
        end
    end

    // MMIO channel decode: read word, one-hot request mask and slow flag of the indexed channel.
    always_comb begin
        mmio_word_s   = '0;
        mmio_hit_s    = 1'b0;
        mmio_slow_s   = 1'b0;
        mmio_onehot_s = '0;
        for (int i = 0; i < N_MMIO; i++) begin
            if (mmio_idx_s == IDX_W'(i)) begin
                mmio_word_s      = mmio_rdata[i*XLEN +: XLEN];
                mmio_hit_s       = 1'b1;
                mmio_slow_s      = SLOW_MASK[i];
                mmio_onehot_s[i] = 1'b1;
            end else begin
                mmio_onehot_s[i] = 1'b0;
            end
        end
    end

    // Writeback source classification.
    always_comb begin
        if (is_jump_s) begin
            src_s = SRC_PC4;
        end else if (!is_load_s) begin
            src_s = SRC_ALU;
        end else if (w_addr_q[31:28] == REGION_BIOS) begin
            src_s = SRC_BIOS;
        end else if (mmio_region_s) begin
            src_s = SRC_MMIO;
        end else begin
            src_s = SRC_DMEM;
        end
    end

    // Raw value before sub-word extraction; malformed MMIO addresses read as zero.
    always_comb begin
        raw_s = '0;
        case (src_s)
            SRC_PC4:  raw_s = w_pc_q + XLEN'(4);
            SRC_ALU:  raw_s = w_addr_q;
            SRC_BIOS: raw_s = bios_rdata;
            SRC_DMEM: raw_s = dmem_rdata;
            SRC_MMIO: raw_s = mmio_ok_s ? mmio_word_s : '0;
            default:  raw_s = '0;
        endcase
    end

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .data_i   (raw_s),
        .funct3_i (funct3_s),
        .offset_i (w_addr_q[1:0]),
        .data_o   (aligned_s)
    );

    assign result_s    = is_load_s ? aligned_s : raw_s;
    assign slow_load_s = w_valid_q && is_load_s && (src_s == SRC_MMIO) && mmio_ok_s && mmio_slow_s;
    assign ack_hit_s   = mmio_ok_s && ((mmio_ack & mmio_onehot_s) != '0);

`ifdef WB_MMIO_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counts WAIT cycles; RUN clears it so each WAIT entry starts from zero.
    always_comb begin
        if (state_q == ST_WAIT) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end else begin
            tmo_cnt_d = '0;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign tmo_hit_s = (state_q == ST_WAIT) && (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT;
    assign tmo_hit_s = 1'b0;
`endif

    // RUN/WAIT handshake; an ack arriving together with the timeout wins.
    always_comb begin
        state_d   = state_q;
        stall_s   = 1'b0;
        bus_err_s = 1'b0;
        req_s     = '0;
        case (state_q)
            ST_RUN: begin
                if (slow_load_s) begin
                    stall_s = 1'b1;
                    req_s   = mmio_onehot_s;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (ack_hit_s) begin
                    state_d = ST_RUN;
                end else if (tmo_hit_s) begin
                    bus_err_s = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign stall    = stall_s;
    assign mmio_req = req_s;
    assign bus_err  = bus_err_s;
    assign wb_rd    = rd_s;
    assign wb_we    = w_valid_q && !stall_s && writes_rd(opcode_s) && (rd_s != 5'd0);
    assign wb_data  = bus_err_s ? '0 : result_s;

endmodule

// File: doc/wb_stage_unit.md
Name: wb_stage_unit

Overview:
- Registered writeback stage of the RISC-V core. Successor to the combinational writeback select logic.
- Owns the X→W pipeline register and classifies the writeback source: ALU, PC+4, DMEM, BIOS, or one of N MMIO channels.
- Performs sub-word load extraction.
- Stalls the pipeline for slow MMIO channels through a req/ack handshake.

Parameters:
- XLEN, 32, datapath width.
- N_MMIO, 8, number of MMIO read channels; channel i sits at MMIO_BASE + 4*i.
- MMIO_BASE, 32'h8000_0000, base address of the MMIO region.
- SLOW_MASK, 8'b1100_0000, bit i set means channel i needs the req/ack handshake.
- TIMEOUT, 64, cycles in WAIT before a bus error (used only with the optional feature).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- x_valid  in  1  X-stage instruction valid.
- x_inst  in  XLEN  X-stage instruction.
- x_addr  in  XLEN  X-stage ALU result (load address or result value).
- x_pc  in  XLEN  X-stage PC.
- dmem_rdata  in  XLEN  DMEM synchronous read data; valid in W.
- bios_rdata  in  XLEN  BIOS synchronous read data; valid in W.
- mmio_rdata  in  N_MMIO*XLEN  per-channel read data, channel i at [i*XLEN +: XLEN].
- mmio_ack  in  N_MMIO  per-channel completion strobe.
- mmio_req  out  N_MMIO  one-hot, single-cycle request pulse.
- stall  out  1  freezes the F/D/X stages and this unit's W register.
- wb_we  out  1  register-file write enable.
- wb_rd  out  5  destination register.
- wb_data  out  XLEN  writeback value.
- bus_err  out  1  single-cycle MMIO timeout pulse.

Behaviour:
- W register: when stall=0, captures x_valid/x_inst/x_addr/x_pc into w_*. When stall=1, holds its contents.
- Reset: w_valid=0, FSM=RUN; all outputs are 0.
- Source select in W:
  - JAL/JALR → w_pc+4.
  - Non-load → w_addr.
  - Load with w_addr[31:28]==4'h4 → BIOS.
  - Load with w_addr[31:28]==MMIO_BASE[31:28] → MMIO channel idx=w_addr[2 +: clog2(N_MMIO)]. Address bits between the index and 28 must be 0 and idx<N_MMIO; otherwise the raw data is 0.
  - Any other load → DMEM.
- Load extraction (funct3), applied to every load source:
  - LB/LBU use byte w_addr[1:0].
  - LH/LHU use half w_addr[1]; w_addr[0] is ignored.
  - LW uses the full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- wb_we = w_valid & ~stall & (type ∈ {R, I, load, U, JAL, JALR}) & rd≠0. S/B types never write. wb_rd = w_inst[11:7].
- FSM has two states, RUN and WAIT.
  - RUN, no slow load: stall=0. The result is produced combinationally from W contents (0-cycle latency after capture).
  - RUN, valid load to channel i with SLOW_MASK[i]=1: stall=1, wb_we=0, mmio_req[i]=1 for this cycle only; next state WAIT.
  - WAIT: stall=1, mmio_req=0, for as long as mmio_ack[i]=0.
  - WAIT, cycle with mmio_ack[i]=1: stall=0; wb_data = extract(mmio_rdata[i]); wb_we per the rule above; next state RUN.
  - Fast channels (SLOW_MASK[i]=0) read mmio_rdata[i] directly in RUN, with no request.
- Minimum slow-load latency: 2 cycles (req cycle, then ack cycle).
- Boundary conditions:
  - Ack in RUN, or ack on a channel other than the pending one: ignored.
  - rst during WAIT: return to RUN, drop the pending load, no write; a late ack is ignored.
  - Out-of-range MMIO index: treated as fast, data 0, no req.
  - Back-to-back slow loads: each issues its own req only after the previous ack.

Optional Feature:
- Macro WB_MMIO_TIMEOUT_EN.
- Defined: a counter starts at WAIT entry. If it reaches TIMEOUT-1 without an ack:
  - bus_err pulses for 1 cycle and stall=0 that cycle;
  - wb_data=0, with wb_we per the rule;
  - FSM returns to RUN.
- Undefined: WAIT lasts indefinitely; bus_err is tied to 0; no counter logic.

Decomposition:
- Package wb_pkg holds:
  - opcode constants (LOAD 7'h03, JAL 7'h6f, JALR 7'h67, OP-IMM 7'h13, CSR 7'h73);
  - load funct3 codes;
  - region nibbles (BIOS 4'h4, MMIO 4'h8);
  - wb_src enum (ALU, PC4, DMEM, BIOS, MMIO);
  - FSM state enum.
- Sub-module load_align: combinational extraction taking (data, funct3, offset) and producing the XLEN result; instantiated once.

Test Plan:
- LW at 0x1000_0004, dmem_rdata=0x8765_4321 → wb_data=0x8765_4321, wb_we=1, stall=0.
- dmem_rdata=0x80xx_xxxx at 0x1000_0003:
  - LB → 0xFFFF_FF80.
  - LBU → 0x0000_0080.
  - LH at 0x1000_0002 with data 0x8000_1234 → 0xFFFF_8000.
- LW at 0x8000_0018 (ch6, slow):
  - Detection cycle: stall=1, mmio_req=0x40 for exactly 1 cycle.
  - Two WAIT cycles with no ack: stall=1.
  - Ack with data 0xAB: stall=0, wb_data=0xAB, wb_we=1.
- JAL at pc 0x100:
  - rd=x1 → wb_data=0x104, wb_we=1.
  - rd=x0 → wb_we=0.
  - SW → wb_we=0.
- rst in the 2nd WAIT cycle, ack one cycle later → stall=0, wb_we=0, FSM=RUN, no write from the late ack.
- With WB_MMIO_TIMEOUT_EN and TIMEOUT=64, slow load with no ack → bus_err pulses once in the 64th WAIT cycle, wb_data=0, wb_we=1, stall then drops.
